reg_file_checker: RTL and testbench

REG_FILE_CHECKER -- requirements
Module: reg_file_checker

---
 rtl/reg_file_checker.sv | 84 ++++++++
 tb/tb_reg_file_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_file_checker.sv
// reg_file_checker: scans a register file against an internal expected table and reports mismatches.
// Optional mismatch trace port (mm_valid/mm_idx/mm_actual) enabled by REG_CHECK_MISMATCH_PORT_EN.
module reg_file_checker #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              exp_we,
  input  logic [4:0]        exp_waddr,
  input  logic [DATA_W-1:0] exp_wdata,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [5:0]        err_count,
  output logic [4:0]        first_err_idx,
  output logic              first_err_valid
`ifdef REG_CHECK_MISMATCH_PORT_EN
  ,
  output logic              mm_valid,
  output logic [4:0]        mm_idx,
  output logic [DATA_W-1:0] mm_actual
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);
  state_t            state, state_nx;
  logic [DATA_W-1:0] exp_mem [NUM_REGS];
  logic              cmp_valid;
  logic [4:0]        cmp_idx;
  logic              mism;
  logic [5:0]        err_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? SCAN : IDLE) :
               state == SCAN ? (rf_raddr == LAST ? DRAIN : SCAN) :
               state == DRAIN ? DONE : IDLE;
    mism     = cmp_valid && (rf_rdata !== exp_mem[cmp_idx]);
    err_nx   = (mism && err_count != 6'd63) ? err_count + 6'd1 : err_count;
  end
  assign busy = state == SCAN || state == DRAIN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (state == IDLE && exp_we && exp_waddr <= LAST)
      exp_mem[exp_waddr] <= exp_wdata;
  end
  // cmp_idx trails rf_raddr by one cycle to line up with the read latency
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state           <= IDLE;
      rf_raddr        <= '0;
      cmp_valid       <= 1'b0;
      cmp_idx         <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      rf_raddr  <= (state == SCAN && rf_raddr != LAST) ? rf_raddr + 5'd1 : 5'd0;
      cmp_valid <= state == SCAN;
      cmp_idx   <= rf_raddr;
      if (state == IDLE && start) begin
        err_count       <= '0;
        first_err_valid <= 1'b0;
        pass            <= 1'b0;
      end else begin
        err_count <= err_nx;
        if (mism && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= cmp_idx;
        end
        if (state == DRAIN) pass <= err_nx == 6'd0;
      end
    end
  end
`ifdef REG_CHECK_MISMATCH_PORT_EN
  assign mm_valid  = mism;
  assign mm_idx    = mism ? cmp_idx : '0;
  assign mm_actual = mism ? rf_rdata : '0;
`endif
endmodule

// File: tb/tb_reg_file_checker.sv
// tb_reg_file_checker: directed and randomized scans checked against a per-index reference model.
module tb_reg_file_checker;
  logic        clk = 0, rstb = 1, start = 0, exp_we = 0;
  logic [4:0]  exp_waddr = 0;
  logic [31:0] exp_wdata = 0, rf_rdata = 0;
  logic [4:0]  rf_raddr, first_err_idx;
  logic        busy, done, pass, first_err_valid;
  logic [5:0]  err_count;
`ifdef REG_CHECK_MISMATCH_PORT_EN
  logic        mm_valid;
  logic [4:0]  mm_idx;
  logic [31:0] mm_actual;
`endif
  int vectors = 0, errs = 0;
  logic [31:0] exp_tab [32];
  logic [31:0] rf_mem [32];

  reg_file_checker #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clk(clk), .rstb(rstb), .start(start), .exp_we(exp_we), .exp_waddr(exp_waddr),
    .exp_wdata(exp_wdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_valid(first_err_valid)
`ifdef REG_CHECK_MISMATCH_PORT_EN
    , .mm_valid(mm_valid), .mm_idx(mm_idx), .mm_actual(mm_actual)
`endif
  );

  always #5 clk = ~clk;
  // core register file: one-cycle read latency
  always @(posedge clk) rf_rdata <= rf_mem[rf_raddr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int mm_below(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (rf_mem[i] !== exp_tab[i]) k++;
    return k;
  endfunction

  function automatic int first_mm();
    for (int i = 0; i < 32; i++) if (rf_mem[i] !== exp_tab[i]) return i;
    return -1;
  endfunction

  task automatic load_table();
    for (int i = 0; i < 32; i++) begin
      exp_we = 1; exp_waddr = 5'(i); exp_wdata = exp_tab[i];
      @(negedge clk);
    end
    exp_we = 0;
  endtask

  task automatic run_scan(input bit poke);
    int n, f, e;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= 35; c++) begin
      n = c > 2 ? c - 2 : 0;
      if (n > 32) n = 32;
      e = mm_below(n);
      chk("busy", busy, c <= 33);
      chk("done", done, c == 34);
      if (c <= 32) chk("rf_raddr", rf_raddr, c - 1);
      chk("err_count", err_count, e > 63 ? 63 : e);
`ifdef REG_CHECK_MISMATCH_PORT_EN
      if (c >= 2 && c <= 33) begin
        chk("mm_valid", mm_valid, rf_mem[c-2] !== exp_tab[c-2]);
        if (rf_mem[c-2] !== exp_tab[c-2]) begin
          chk("mm_idx", mm_idx, c - 2);
          chk("mm_actual", mm_actual, rf_mem[c-2]);
        end
      end else chk("mm_valid_idle", mm_valid, 0);
`endif
      if (c >= 34) begin
        f = first_mm();
        chk("pass", pass, f < 0);
        chk("first_err_valid", first_err_valid, f >= 0);
        if (f >= 0) chk("first_err_idx", first_err_idx, f);
      end
      if (poke && c == 5) begin
        start = 1; exp_we = 1; exp_waddr = 5'd20; exp_wdata = ~exp_tab[20];
      end else begin
        start = 0; exp_we = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'(i * 4);
      exp_tab[i] = 32'(i * 4);
    end
    repeat (2) @(negedge clk);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err_idx", first_err_idx, 0);
    chk("rst_first_err_valid", first_err_valid, 0);
    rstb = 0;
    @(negedge clk);
    load_table();
    run_scan(0);
    rf_mem[10] = 32'hDEADBEEF;
    run_scan(0);
    rf_mem[10] = 32'h28; rf_mem[0] = 32'h1; rf_mem[31] = 32'h0;
    run_scan(0);
    rf_mem[0] = 32'h0; rf_mem[31] = 32'(31 * 4);
    run_scan(1);
    run_scan(0);
    repeat (4) begin
      for (int i = 0; i < 32; i++) begin
        exp_tab[i] = $urandom;
        rf_mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : exp_tab[i];
      end
      load_table();
      run_scan(0);
    end
    for (int i = 0; i < 32; i++) rf_mem[i] = ~exp_tab[i];
    run_scan(0);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (11) @(negedge clk);
    rstb = 1;
    #1;
    chk("arst_raddr", rf_raddr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_first_err_idx", first_err_idx, 0);
    chk("arst_first_err_valid", first_err_valid, 0);
`ifdef REG_CHECK_MISMATCH_PORT_EN
    chk("arst_mm_valid", mm_valid, 0);
`endif
    @(negedge clk);
    rstb = 0;
    for (int c = 0; c < 30; c++) begin
      chk("no_done_after_abort", done, 0);
      @(negedge clk);
    end
    run_scan(0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
